// File: rtl/vid_mode_ctrl.sv
// vid_mode_ctrl
//   Sequences video mode changes. A debounced press of the mode button steps
//   the mode index; the vidcon is held in reset while the pixel-clock mux and
//   modeline ROMs settle on the new index, the new modeline is latched in one
//   shot, and video is released again. Reset loads mode 0 with no press.
//
// Ports
//   sys_clk       in   1       system clock, sole clock domain
//   act_reset     in   1       synchronous reset, active-high
//   but_center    in   1       raw asynchronous mode button
//   rom_h         in   49      {hsi,hdisp,hstart,hend,htotal} for mode_sel
//   rom_v         in   49      {vsi,vdisp,vstart,vend,vtotal} for mode_sel
//   mode_req      in   1       direct mode request (VID_MODE_DIRECT_EN only)
//   mode_req_idx  in   MODE_W  requested mode index (VID_MODE_DIRECT_EN only)
//   mode_sel      out  MODE_W  mode index to ROM address and pixel-clock mux
//   mline_h       out  49      latched horizontal modeline
//   mline_v       out  49      latched vertical modeline
//   mline_load    out  1       one-cycle pulse while the new modeline is shown
//   vid_reset     out  1       active-high reset to the vidcon
//   busy          out  1       high whenever a mode change is in progress
//
// Build option
//   VID_MODE_DIRECT_EN  adds mode_req/mode_req_idx so the CPU can jump
//                       straight to a mode; a direct request beats a
//                       simultaneous button trigger.

module vid_mode_ctrl #(
    parameter int NUM_MODES       = 4,
    parameter int MODE_W          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16,
    parameter int SETTLE_CYCLES   = 256
) (
    input  logic              sys_clk,
    input  logic              act_reset,
    input  logic              but_center,
    input  logic [48:0]       rom_h,
    input  logic [48:0]       rom_v,
`ifdef VID_MODE_DIRECT_EN
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_req_idx,
`endif
    output logic [MODE_W-1:0] mode_sel,
    output logic [48:0]       mline_h,
    output logic [48:0]       mline_v,
    output logic              mline_load,
    output logic              vid_reset,
    output logic              busy
);

    localparam int DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PHASE_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W     = $clog2(PHASE_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [MODE_W-1:0] LAST_MODE   = MODE_W'(NUM_MODES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SWITCH,
        S_SETTLE,
        S_LATCH,
        S_RELEASE
    } state_t;

    state_t             state;
    state_t             next_state;

    logic               but_meta;
    logic               but_sync;
    logic               but_deb;
    logic [DEB_W-1:0]   deb_cnt;
    logic               trig;

    logic [CNT_W-1:0]   phase_cnt;
    logic [MODE_W-1:0]  target_mode;
    logic [MODE_W-1:0]  step_mode;
    logic [MODE_W-1:0]  start_mode;
    logic               start;

    // Button front end. The debounced level only follows the synchronised
    // level after it has disagreed for DEBOUNCE_CYCLES consecutive cycles;
    // any agreement restarts the count. Only press edges raise trig.
    always_ff @(posedge sys_clk) begin
        if (act_reset) begin
            but_meta <= 1'b0;
            but_sync <= 1'b0;
            but_deb  <= 1'b0;
            deb_cnt  <= '0;
            trig     <= 1'b0;
        end else begin
            but_meta <= but_center;
            but_sync <= but_meta;
            trig     <= 1'b0;
            if (but_sync == but_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                but_deb <= but_sync;
                deb_cnt <= '0;
                trig    <= but_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Choice of the mode to switch to; only consulted while idle, so any
    // request arriving mid-sequence is simply lost.
    assign step_mode = (mode_sel == LAST_MODE) ? '0 : mode_sel + MODE_W'(1);

`ifdef VID_MODE_DIRECT_EN
    logic [MODE_W-1:0]  req_mode;
    localparam logic [31:0] NUM_MODES_U = NUM_MODES;

    assign req_mode   = (32'(mode_req_idx) >= NUM_MODES_U) ? LAST_MODE : mode_req_idx;
    assign start      = mode_req | trig;
    assign start_mode = mode_req ? req_mode : step_mode;
`else
    assign start      = trig;
    assign start_mode = step_mode;
`endif

    // State register. Reset lands in SETTLE with mode 0 already selected so
    // the mode 0 modeline gets loaded without a button press.
    always_ff @(posedge sys_clk) begin
        if (act_reset) begin
            state <= S_SETTLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and outputs. vid_reset stays asserted through every step
    // of a change so the vidcon never sees a half-updated mode.
    always_comb begin
        next_state = state;
        vid_reset  = 1'b1;
        busy       = 1'b1;
        mline_load = 1'b0;
        case (state)
            S_IDLE: begin
                vid_reset = 1'b0;
                busy      = 1'b0;
                if (start) begin
                    next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (phase_cnt == HOLD_LAST) begin
                    next_state = S_SWITCH;
                end
            end
            S_SWITCH: begin
                next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (phase_cnt == SETTLE_LAST) begin
                    next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                mline_load = 1'b1;
                next_state = S_RELEASE;
            end
            S_RELEASE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: phase counter for HOLD/SETTLE, target mode capture, the
    // mode_sel update at the end of SWITCH, and the single-edge modeline
    // capture on leaving SETTLE so mline_h/v never show a mix of old and new.
    always_ff @(posedge sys_clk) begin
        if (act_reset) begin
            phase_cnt   <= '0;
            target_mode <= '0;
            mode_sel    <= '0;
            mline_h     <= '0;
            mline_v     <= '0;
        end else begin
            if (next_state != state || state == S_IDLE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
            if (state == S_IDLE && start) begin
                target_mode <= start_mode;
            end
            if (state == S_SWITCH) begin
                mode_sel <= target_mode;
            end
            if (state == S_SETTLE && next_state == S_LATCH) begin
                mline_h <= rom_h;
                mline_v <= rom_v;
            end
        end
    end

endmodule
